// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, mode encoding and real-valued helpers
// used at elaboration time to build the gain constant.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAIN = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_t;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) begin
      for (int k = 0; k < n; k++) r = r * 2.0;
    end else begin
      for (int k = 0; k < -n; k++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic real real_sqrt(input real a);
    real g;
    g = (a > 1.0) ? a : 1.0;
    for (int k = 0; k < 60; k++) g = 0.5 * (g + a / g);
    return g;
  endfunction

  // K = 1/An = prod 1/sqrt(1 + 2^-2i), scaled by 2^(width-1), round half up
  function automatic logic [63:0] gain_k(input int iters, input int width);
    real p;
    p = 1.0;
    for (int k = 0; k < iters; k++) p = p * (1.0 + pow2(-2 * k));
    return longint'($floor(pow2(width - 1) / real_sqrt(p) + 0.5));
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: entry i = round(atan(2^-i) * 2^(WIDTH-1) / pi),
// evaluated at elaboration with a power series so no runtime math is needed.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [IW-1:0]           idx,
  output logic signed [WIDTH-1:0] atan
);

  localparam real PI = 3.14159265358979323846;

  function automatic logic [63:0] atan_scaled(input int n, input int width);
    real x, term, sum;
    if (n == 0) begin
      sum = PI / 4.0;
    end else begin
      x    = pow2(-n);
      term = x;
      sum  = 0.0;
      for (int k = 0; k < 64; k++) begin
        sum  = ((k % 2) == 0) ? sum + term / real'(2 * k + 1) : sum - term / real'(2 * k + 1);
        term = term * x * x;
      end
    end
    return longint'($floor(sum * pow2(width - 1) / PI + 0.5));
  endfunction

  logic [WIDTH-1:0] rom [2**IW];

  for (genvar g = 0; g < 2**IW; g++) begin : g_rom
    localparam logic [63:0] V = atan_scaled(g, WIDTH);
    assign rom[g] = V[WIDTH-1:0];
  end

  assign atan = rom[idx];

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC core, one micro-rotation per clock in rotation or vectoring mode.
// Define CORDIC_GAIN_COMP_EN to add a GAIN state that scales x/y by K = 1/An.
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    busy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(ITERS - 1);

  state_t                  state;
  mode_t                   mode_q;
  logic [IW-1:0]           i;
  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] atan_i;
  logic signed [WIDTH-1:0] x_sh, y_sh, x_rot, y_rot, z_rot;
  logic                    dir_pos;

  cordic_atan_rom #(.WIDTH(WIDTH), .IW(IW)) u_atan_rom (
    .idx  (i),
    .atan (atan_i)
  );

  // Vectoring steers on -y >= 0, i.e. y <= 0 taken mathematically
  always_comb begin
    x_sh    = x_q >>> i;
    y_sh    = y_q >>> i;
    dir_pos = (mode_q == MODE_ROT) ? !z_q[WIDTH-1] : (y_q[WIDTH-1] || (y_q == '0));
    if (dir_pos) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_i;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_i;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDTH:0] K = {1'b0, WIDTH'(gain_k(ITERS, WIDTH))};
  logic signed [2*WIDTH:0] x_prod, y_prod;
  logic signed [WIDTH-1:0] x_gain, y_gain;
  assign x_prod = x_q * K;
  assign y_prod = y_q * K;
  assign x_gain = x_prod[2*WIDTH-2:WIDTH-1];
  assign y_gain = y_prod[2*WIDTH-2:WIDTH-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_ROT;
      i         <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q   <= mode_t'(mode);
            x_q      <= x_in;
            y_q      <= y_in;
            z_q      <= z_in;
            i        <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          x_q <= x_rot;
          y_q <= y_rot;
          z_q <= z_rot;
          i   <= i + 1'b1;
          if (i == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state     <= GAIN;
`else
            state     <= DONE;
            out_valid <= 1'b1;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          x_q       <= x_gain;
          y_q       <= y_gain;
          state     <= DONE;
          out_valid <= 1'b1;
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x_out = x_q;
  assign y_out = y_q;
  assign z_out = z_q;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Bench for cordic_iter_core (WIDTH=16, ITERS=14): directed cases plus random
// operations against a real-math based reference. Honours CORDIC_GAIN_COMP_EN.
module tb_cordic_iter_core;

  localparam int W = 16;
  localparam int N = 14;
  localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT    = N + 1;
  localparam int ROT_X  = 16384;
  localparam int TOL_XY = 6;
  localparam int VEC_X  = 14142;
`else
  localparam int LAT    = N;
  localparam int ROT_X  = 9949;
  localparam int TOL_XY = 4;
  localparam int VEC_X  = 23290;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic                mode;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out, y_out, z_out;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cordic_iter_core #(.WIDTH(W), .ITERS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = (obs > exp) ? obs - exp : exp - obs;
    n_checks++;
    assert (diff <= tol)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int atan_ref(input int k);
    return int'($floor($atan(1.0 / (2.0 ** k)) * 32768.0 / PI + 0.5));
  endfunction

  function automatic int k_ref();
    real p;
    p = 1.0;
    for (int k = 0; k < N; k++) p = p * (1.0 + 1.0 / (4.0 ** k));
    return int'($floor(32768.0 / $sqrt(p) + 0.5));
  endfunction

  // Reference: N greedy micro-rotations with 16-bit wrap, optional 1/An scaling
  task automatic model(input bit m, input int xi, input int yi, input int zi,
                       output int xo, output int yo, output int zo);
    logic signed [W-1:0] x, y, z, xs, ys;
    bit                  pos;
    x = W'(xi);
    y = W'(yi);
    z = W'(zi);
    for (int k = 0; k < N; k++) begin
      pos = m ? (int'(y) <= 0) : (int'(z) >= 0);
      xs  = x >>> k;
      ys  = y >>> k;
      if (pos) begin
        x = x - ys; y = y + xs; z = z - W'(atan_ref(k));
      end else begin
        x = x + ys; y = y - xs; z = z + W'(atan_ref(k));
      end
    end
`ifdef CORDIC_GAIN_COMP_EN
    x = W'((int'(x) * k_ref()) >>> 15);
    y = W'((int'(y) * k_ref()) >>> 15);
`endif
    xo = int'(x);
    yo = int'(y);
    zo = int'(z);
  endtask

  // Starts at a negedge with the core idle; returns at the negedge where out_valid is seen
  task automatic apply_stimulus(input bit m, input int xi, input int yi, input int zi,
                                output int xo, output int yo, output int zo, output int lat);
    in_valid = 1'b1;
    mode     = m;
    x_in     = W'(xi);
    y_in     = W'(yi);
    z_in     = W'(zi);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    xo = int'(x_out);
    yo = int'(y_out);
    zo = int'(z_out);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input bit m, input int xi, input int yi, input int zi);
    int xo, yo, zo, lat, ex, ey, ez;
    model(m, xi, yi, zi, ex, ey, ez);
    apply_stimulus(m, xi, yi, zi, xo, yo, zo, lat);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_x"}, xo, ex);
    check({tag, "_y"}, yo, ey);
    check({tag, "_z"}, zo, ez);
    release_result();
  endtask

  initial begin
    int xo, yo, zo, lat, ex, ey, ez;
    int hx, hy, hz, cycle, seen;
    int acc[$];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = 1'b0;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x_out", int'(x_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);

    // Rotation by 45 degrees
    model(1'b0, ROT_X, 0, 8192, ex, ey, ez);
    apply_stimulus(1'b0, ROT_X, 0, 8192, xo, yo, zo, lat);
    check("rot_lat", lat, LAT);
    check_near("rot_x", xo, 11585, TOL_XY);
    check_near("rot_y", yo, 11585, TOL_XY);
    check_near("rot_z", zo, 0, 2);
    check("rot_x_exact", xo, ex);
    check("rot_z_exact", zo, ez);
    release_result();

    // Vectoring of (10000, 10000)
    model(1'b1, 10000, 10000, 0, ex, ey, ez);
    apply_stimulus(1'b1, 10000, 10000, 0, xo, yo, zo, lat);
    check("vec_lat", lat, LAT);
    check_near("vec_x", xo, VEC_X, TOL_XY);
    check_near("vec_y", yo, 0, 2);
    check_near("vec_z", zo, 8192, 2);
    check("vec_y_exact", yo, ey);
    release_result();

    // Backpressure: hold out_ready low in DONE, in_valid must be ignored
    out_ready = 1'b0;
    apply_stimulus(1'b0, 5000, -3000, -6000, hx, hy, hz, lat);
    model(1'b0, 5000, -3000, -6000, ex, ey, ez);
    check("bp_x", hx, ex);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_x_stable", int'(x_out), hx);
      check("bp_y_stable", int'(y_out), hy);
      check("bp_z_stable", int'(z_out), hz);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_busy", int'(busy), 0);
    check("bp_release_ready", int'(in_ready), 1);

    // Reset in the middle of RUN after five micro-rotations
    in_valid = 1'b1;
    mode     = 1'b0;
    x_in     = 16'sd7000;
    y_in     = 16'sd0;
    z_in     = 16'sd4000;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy", int'(busy), 1);
    check("mid_in_ready", int'(in_ready), 0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_in_ready", int'(in_ready), 1);
    seen = 0;
    repeat (LAT + 3) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_no_result", seen, 0);
    check_output("post_rst", 1'b0, 7000, 0, 4000);

    // Throughput with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    mode      = 1'b0;
    x_in      = W'(ROT_X);
    y_in      = '0;
    z_in      = 16'sh2000;
    cycle     = 0;
    repeat (60) begin
      if (in_ready) acc.push_back(cycle);
      if (out_valid) begin
        check_near("tp_x", int'(x_out), 11585, TOL_XY);
        check_near("tp_y", int'(y_out), 11585, TOL_XY);
      end
      @(posedge clk);
      @(negedge clk);
      cycle++;
    end
    in_valid = 1'b0;
    check("tp_accepts", acc.size(), 4);
    for (int k = 1; k < acc.size(); k++) check("tp_spacing", acc[k] - acc[k-1], LAT + 2);
    seen = 0;
    while (!in_ready && seen < 60) begin
      @(posedge clk);
      @(negedge clk);
      seen++;
    end
    check("tp_drain_idle", int'(in_ready), 1);

    // Random operations inside the convergence domain
    for (int n = 0; n < 20; n++) begin
      if (n % 2 == 0)
        check_output("rnd_rot", 1'b0, int'($urandom_range(0, 16000)) - 8000,
                     int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 32000)) - 16000);
      else
        check_output("rnd_vec", 1'b1, int'($urandom_range(1, 8000)),
                     int'($urandom_range(0, 16000)) - 8000, int'($urandom_range(0, 8000)) - 4000);
    end

    // Full-range operands: results follow the same rules and the FSM must not hang
    for (int n = 0; n < 4; n++)
      check_output("rnd_full", n[0], int'($urandom_range(0, 65535)) - 32768,
                   int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
